cnn_icb_sram_slv: RTL and testbench

ICB responder that backs the CNN core's ICB master port with a local word-addressed SRAM for feature maps, weights and results. It accepts read/write commands, performs byte-masked writes and synchronous reads, and returns one response per command in order through a 2-entry response FIFO. The FIFO decouples response back-pressure from command acceptance. It sits on the cnn_icb_* bus, opposite cnn_core.

---
 rtl/cnn_icb_sram_slv.sv | 110 +++++++++++
 tb/tb_cnn_icb_sram_slv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_icb_sram_slv.sv
// ICB responder backed by a local word-addressed SRAM, with an in-order 2-entry response FIFO.
// Define CNN_SRAM_ERR_EN to flag out-of-range commands with icb_rsp_err instead of aliasing them.
module cnn_icb_sram_slv #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       fifo_data_q [2];
    logic [1:0]        count_q, count_d;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [MEM_AW-1:0] idx;
    logic              cmd_err;
    logic              accept;
    logic              pop;
    logic              wr_en;
    logic [31:0]       push_data;
    logic              unused_addr;

    assign idx = icb_cmd_addr[MEM_AW+1:2];

`ifdef CNN_SRAM_ERR_EN
    logic [1:0] fifo_err_q;

    assign cmd_err     = (icb_cmd_addr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);
    assign unused_addr = ^icb_cmd_addr[1:0];
`else
    // Without error checking the window aliases across the whole address space.
    assign cmd_err     = 1'b0;
    assign unused_addr = ^{icb_cmd_addr[31:MEM_AW+2], icb_cmd_addr[1:0], BASE_ADDR};
`endif

    // Ready depends only on the registered occupancy, never on icb_rsp_ready.
    assign icb_cmd_ready = (count_q < 2'd2);
    assign icb_rsp_valid = (count_q != 2'd0);
    assign accept        = icb_cmd_valid & icb_cmd_ready;
    assign pop           = icb_rsp_valid & icb_rsp_ready;
    assign wr_en         = accept & ~icb_cmd_read & ~cmd_err;
    assign push_data     = (icb_cmd_read && !cmd_err) ? mem_q[idx] : 32'h0;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (accept) begin
            wptr_d = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // SRAM and FIFO payload carry no reset; visibility is governed by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (icb_cmd_wmask[b]) begin
                    mem_q[idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
                end
            end
        end
        if (accept) begin
            fifo_data_q[wptr_q] <= push_data;
`ifdef CNN_SRAM_ERR_EN
            fifo_err_q[wptr_q]  <= cmd_err;
`endif
        end
    end

    assign icb_rsp_rdata = icb_rsp_valid ? fifo_data_q[rptr_q] : 32'h0;
`ifdef CNN_SRAM_ERR_EN
    assign icb_rsp_err   = icb_rsp_valid & fifo_err_q[rptr_q];
`else
    assign icb_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_icb_sram_slv.sv
// Scoreboard bench for cnn_icb_sram_slv: stimulus pushes expected responses, a monitor pops and compares.
module tb_cnn_icb_sram_slv;

    localparam int          MEM_AW = 10;
    localparam logic [31:0] BASE   = 32'h2000_0000;

    logic        clk;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    cnn_icb_sram_slv #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          known;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mdl [int];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rsp_mode = 1;   // 0: stall, 1: always ready, 2: random
    bit          lat_chk = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: the window is the aligned 2**(MEM_AW+2) byte region at BASE; word index from bits [MEM_AW+1:2].
    task automatic model(input logic [31:0] addr, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
        exp_t e;
        int   wi;
        bit   in_range;
        logic [31:0] word;
        wi       = int'((addr / 4) % (1 << MEM_AW));
        in_range = (addr / (1 << (MEM_AW + 2))) == (BASE / (1 << (MEM_AW + 2)));
        e.rdata   = 32'h0;
        e.err     = 1'b0;
        e.known   = 1'b1;
        e.acc_cyc = cyc;
        e.chk_lat = lat_chk;
`ifdef CNN_SRAM_ERR_EN
        if (!in_range) begin
            e.err = 1'b1;
            expq.push_back(e);
            return;
        end
`else
        in_range = 1'b1;
`endif
        if (rd) begin
            if (mdl.exists(wi)) e.rdata = mdl[wi];
            else e.known = 1'b0;
        end else begin
            word = mdl.exists(wi) ? mdl[wi] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (wm[b]) word[8*b +: 8] = wd[8*b +: 8];
            if (mdl.exists(wi) || wm == 4'hF) mdl[wi] = word;
        end
        expq.push_back(e);
    endtask

    task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
        int n;
        n = 0;
        @(negedge clk);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = addr;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        while (!icb_cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!icb_cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed %b, expected 1", icb_cmd_ready);
            icb_cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model(addr, rd, wd, wm);
    endtask

    task automatic idle();
        @(negedge clk);
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rsp_mode = 1;
        idle();
        while (expq.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, expq.size(), 0);
    endtask

    // Response-ready driver, changes only just after the active edge.
    initial begin
        icb_rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rsp_mode)
                0:       icb_rsp_ready = 1'b0;
                1:       icb_rsp_ready = 1'b1;
                default: icb_rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every handshaked response is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && icb_rsp_valid && icb_rsp_ready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_rsp: rsp_valid=1 with rdata %h, expected no response", icb_rsp_rdata);
                end else begin
                    e = expq.pop_front();
                    if (e.known) check("rsp_rdata", icb_rsp_rdata, e.rdata);
                    check("rsp_err", 32'(icb_rsp_err), 32'(e.err));
                    if (e.chk_lat) check("rsp_latency_cycle", cyc, e.acc_cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] head;
        logic [31:0] addr;
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", 32'(icb_rsp_valid), 0);
        check("reset_rsp_rdata", icb_rsp_rdata, 0);
        check("reset_rsp_err", 32'(icb_rsp_err), 0);
        check("reset_cmd_ready", 32'(icb_cmd_ready), 1);

        // Zero-wait master: every response must appear exactly one cycle after acceptance.
        rsp_mode = 1;
        lat_chk  = 1;
        for (int i = 0; i < 32; i++) issue(BASE + 32'(i * 4), 1'b0, $urandom, 4'hF);

        issue(BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
        issue(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
        issue(BASE + 32'h12, 1'b0, 32'h1122_3344, 4'b0101);
        issue(BASE + 32'h13, 1'b1, 32'h0, 4'h0);
        issue(BASE + 32'h08, 1'b0, 32'hFFFF_FFFF, 4'h0);
        issue(BASE + 32'h08, 1'b1, 32'h0, 4'h0);
        drain("drain_directed");

        // Back-pressure: two reads fill the FIFO, the head must hold, the third waits.
        rsp_mode = 0;
        lat_chk  = 0;
        @(posedge clk);
        #3;
        issue(BASE + 32'h04, 1'b1, 32'h0, 4'h0);
        issue(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        check("bp_cmd_ready_full", 32'(icb_cmd_ready), 0);
        check("bp_rsp_valid", 32'(icb_rsp_valid), 1);
        check("bp_head_data", icb_rsp_rdata, expq[0].rdata);
        head = icb_rsp_rdata;
        repeat (3) begin
            @(negedge clk);
            check("bp_head_stable", icb_rsp_rdata, head);
        end
        rsp_mode = 1;
        issue(BASE + 32'h0C, 1'b1, 32'h0, 4'h0);
        drain("drain_backpressure");

        // Throughput: eight back-to-back reads, one response per cycle.
        lat_chk = 1;
        for (int i = 0; i < 8; i++) issue(BASE + 32'(i * 4), 1'b1, 32'h0, 4'h0);
        drain("drain_throughput");

        // Address just above the window: error when checking is enabled, aliases word 0 otherwise.
        addr = BASE + (32'd4 << MEM_AW);
        issue(addr, 1'b1, 32'h0, 4'h0);
        issue(addr, 1'b0, 32'hA5A5_5A5A, 4'hF);
        issue(BASE, 1'b1, 32'h0, 4'h0);
        issue(addr | 32'h8, 1'b1, 32'h0, 4'h0);
        drain("drain_range");

        // Randomised traffic with random response back-pressure.
        lat_chk  = 0;
        rsp_mode = 2;
        for (int i = 0; i < 300; i++) begin
            addr = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = addr ^ (32'd1 << (MEM_AW + 2 + $urandom_range(0, 3)));
            issue(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 5) == 0) idle();
        end
        drain("drain_random");

        // Reset with a full FIFO: queued responses vanish, SRAM contents survive.
        rsp_mode = 0;
        @(posedge clk);
        #3;
        issue(BASE + 32'h14, 1'b1, 32'h0, 4'h0);
        issue(BASE + 32'h18, 1'b1, 32'h0, 4'h0);
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        check("rst_pre_cmd_ready", 32'(icb_cmd_ready), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_rsp_valid", 32'(icb_rsp_valid), 0);
        check("rst_async_rsp_rdata", icb_rsp_rdata, 0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_post_cmd_ready", 32'(icb_cmd_ready), 1);
        check("rst_post_rsp_valid", 32'(icb_rsp_valid), 0);
        rsp_mode = 1;
        lat_chk  = 1;
        for (int i = 0; i < 8; i++) issue(BASE + 32'(i * 4), 1'b1, 32'h0, 4'h0);
        drain("drain_after_reset");
        repeat (2) @(negedge clk);
        check("final_rsp_valid", 32'(icb_rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
